// File: rtl/mem_port_arbiter.sv
// Merges the CPU instruction and data ports onto one shared memory port, one transaction at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants on ties (default: D-side always wins).
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic              imem_read,
  input  logic              imem_write,
  input  logic [BE_W-1:0]   imem_byte_enable,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [BE_W-1:0]   dmem_byte_enable,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BE_W-1:0]   pmem_byte_enable,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rd_q;
  logic              wr_q;
  logic              req_i;
  logic              req_d;
  logic              pick_d_d;

  assign req_i = imem_read | imem_write;
  assign req_d = dmem_read | dmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_q: 1 = D-side granted most recently
  logic last_grant_q;
  assign pick_d_d = req_d & (~req_i | ~last_grant_q);
`else
  assign pick_d_d = req_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_d_d) begin
            state_q      <= SERVE_D;
            addr_q       <= dmem_address;
            wdata_q      <= dmem_wdata;
            be_q         <= dmem_byte_enable;
            rd_q         <= dmem_read & ~dmem_write;
            wr_q         <= dmem_write;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
          end else if (req_i) begin
            state_q      <= SERVE_I;
            addr_q       <= imem_address;
            wdata_q      <= imem_wdata;
            be_q         <= imem_byte_enable;
            rd_q         <= imem_read & ~imem_write;
            wr_q         <= imem_write;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;
  assign pmem_read        = rd_q;
  assign pmem_write       = wr_q;

  // Responses are routed combinationally; a resp seen in IDLE matches neither owner.
  assign imem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign dmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign imem_rdata = imem_resp ? pmem_rdata : '0;
  assign dmem_rdata = dmem_resp ? pmem_rdata : '0;

`ifndef SYNTHESIS
  a_i_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(imem_read && imem_write))
    else $error("imem_read and imem_write asserted together");
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(dmem_read && dmem_write))
    else $error("dmem_read and dmem_write asserted together");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected grant order follows ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_address, imem_wdata, imem_rdata;
  logic        imem_read, imem_write, imem_resp;
  logic [1:0]  imem_byte_enable;
  logic [15:0] dmem_address, dmem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [1:0]  pmem_byte_enable;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .imem_address(imem_address), .imem_wdata(imem_wdata), .imem_read(imem_read),
    .imem_write(imem_write), .imem_byte_enable(imem_byte_enable),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit rr;
    bit exp_d;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst_n = 1'b0;
    imem_address = '0; imem_wdata = '0; imem_read = 0; imem_write = 0; imem_byte_enable = '0;
    dmem_address = '0; dmem_wdata = '0; dmem_read = 0; dmem_write = 0; dmem_byte_enable = '0;
    pmem_rdata = '0; pmem_resp = 0;
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_addr", pmem_address, 0);
    check("rst_imem_resp", imem_resp, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_no_strobe", {pmem_read, pmem_write}, 0);

    // Lone I read, memory answers three cycles after the grant
    imem_address = 16'h3000; imem_read = 1;
    tick();
    check("t2_read", pmem_read, 1);
    check("t2_addr", pmem_address, 16'h3000);
    tick(); tick(); tick();
    pmem_resp = 1; pmem_rdata = 16'hBEEF;
    #1;
    check("t2_iresp", imem_resp, 1);
    check("t2_irdata", imem_rdata, 16'hBEEF);
    check("t2_dresp", dmem_resp, 0);
    tick();
    pmem_resp = 0; imem_read = 0;
    check("t2_iresp_pulse", imem_resp, 0);
    check("t2_idle", pmem_read, 0);

    // Simultaneous I read and D write: D served first
    imem_address = 16'h1000; imem_read = 1;
    dmem_address = 16'h2000; dmem_wdata = 16'h1234; dmem_byte_enable = 2'b01; dmem_write = 1;
    tick();
    check("t3_write", pmem_write, 1);
    check("t3_read", pmem_read, 0);
    check("t3_addr", pmem_address, 16'h2000);
    check("t3_wdata", pmem_wdata, 16'h1234);
    check("t3_be", pmem_byte_enable, 2'b01);
    dmem_address = 16'h4444;
    tick();
    check("t4_addr_held", pmem_address, 16'h2000);
    pmem_resp = 1; pmem_rdata = 16'h5555;
    #1;
    check("t4_addr_at_resp", pmem_address, 16'h2000);
    check("t3_dresp", dmem_resp, 1);
    check("t3_drdata", dmem_rdata, 16'h5555);
    check("t3_iresp", imem_resp, 0);
    check("t3_irdata", imem_rdata, 0);
    tick();
    pmem_resp = 0; dmem_write = 0;
    check("t3_idle_gap", {pmem_read, pmem_write}, 0);
    tick();
    check("t3_iread", pmem_read, 1);
    check("t3_iaddr", pmem_address, 16'h1000);
    pmem_resp = 1; pmem_rdata = 16'h0F0F;
    #1;
    check("t3_iresp2", imem_resp, 1);
    tick();
    pmem_resp = 0;

    // Both sides requesting continuously for six transactions
    imem_address = 16'h1111; imem_read = 1;
    dmem_address = 16'h2222; dmem_read = 1;
    for (int i = 0; i < 6; i++) begin
      exp_d = rr ? (i % 2 == 0) : 1'b1;
      tick();
      check("t5_addr", pmem_address, exp_d ? 16'h2222 : 16'h1111);
      check("t5_read", pmem_read, 1);
      pmem_resp = 1; pmem_rdata = 16'hA000 + 16'(i);
      #1;
      check("t5_dresp", dmem_resp, exp_d);
      check("t5_iresp", imem_resp, !exp_d);
      tick();
      pmem_resp = 0;
    end
    imem_read = 0; dmem_read = 0;

    // Reset two cycles into SERVE_I, then a stray resp
    tick();
    imem_address = 16'h6000; imem_read = 1;
    tick();
    check("t6_read", pmem_read, 1);
    tick();
    #3;
    rst_n = 0;
    pmem_resp = 1;
    #1;
    check("t6_rst_read", pmem_read, 0);
    check("t6_rst_addr", pmem_address, 0);
    check("t6_rst_iresp", imem_resp, 0);
    check("t6_rst_dresp", dmem_resp, 0);
    imem_read = 0;
    tick();
    rst_n = 1;
    #1;
    check("t6_stray_iresp", imem_resp, 0);
    check("t6_stray_dresp", dmem_resp, 0);
    tick();
    check("t6_stray_iresp2", imem_resp, 0);
    check("t6_idle", {pmem_read, pmem_write}, 0);
    pmem_resp = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
